// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM capture path.
//   pwm_cap_state_t : capture FSM states
//   DUTY_W          : width of the recovered duty code
//   DUTY_MAX        : largest duty code (reported for a stuck-high pin)
//   DUTY_SCALE      : full-scale multiplier applied to high time
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } pwm_cap_state_t;

    localparam int DUTY_W     = 4;
    localparam int DUTY_MAX   = 15;
    localparam int DUTY_SCALE = 15;

endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: 4-step restoring divider, q = floor(n / p) limited to 4 bits.
//   clk, rst : clock, synchronous active-high reset
//   start    : load n/p; steps run on the following 4 cycles
//   n, p     : numerator (CNT_W+4 bits), denominator (CNT_W bits)
//   q        : quotient, valid while done is high
//   done     : high in the 4th cycle after start (final step in progress)
module pwm_duty_div import pwm_pkg::*; #(
    parameter int CNT_W = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W+3:0]  n,
    input  logic [CNT_W-1:0]  p,
    output logic [DUTY_W-1:0] q,
    output logic              done
);
    localparam int NW = CNT_W + 4;

    logic [NW-1:0]     rem, trial;
    logic [CNT_W-1:0]  den;
    logic [1:0]        step;
    logic              busy, ge;
    logic [DUTY_W-1:0] q_r;

    assign trial = NW'(den) << step;
    assign ge    = rem >= trial;

    // If n >= 16p every step succeeds, so the quotient saturates at 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            step <= '0;
            rem  <= '0;
            den  <= '0;
            q_r  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            step <= 2'd3;
            rem  <= n;
            den  <= p;
            q_r  <= '0;
        end else if (busy) begin
            if (ge) rem <= rem - trial;
            q_r[step] <= ge;
            if (step == 2'd0) busy <= 1'b0;
            else              step <= step - 2'd1;
        end
    end

    // Last quotient bit comes straight from the comparator so the result is
    // usable in the final step cycle (q_r[0] is still clear then).
    assign done = busy && (step == 2'd0);
    assign q    = q_r | DUTY_W'(ge);

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: recovers the 4-bit duty code of an incoming PWM waveform.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   pwm_in     : asynchronous PWM pin
//   duty       : last recovered duty code, held between updates
//   duty_valid : one-cycle pulse when duty is written
//   active     : high while a toggling signal is being measured
module pwm_capture import pwm_pkg::*; #(
    parameter int CNT_W       = 21,
    parameter int TIMEOUT_CYC = 1_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              active
);
    localparam int               NW      = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT_CYC);

    // Synchronizer plus one delay flop for edge detection.
    logic sync1, s, s_d, rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            s     <= sync1;
            s_d   <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Period / high-time / edge-silence counters, all saturating.
    logic [CNT_W-1:0] per_cnt, high_cnt, idle_cnt;
    logic             to_armed, tmo, disarm;

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt  <= '0;
            high_cnt <= '0;
            idle_cnt <= '0;
            to_armed <= 1'b1;
        end else begin
            if (rise) begin
                per_cnt  <= CNT_W'(1);
                high_cnt <= CNT_W'(s);
            end else begin
                if (per_cnt != CNT_SAT)      per_cnt  <= per_cnt + 1'b1;
                if (s && high_cnt != CNT_SAT) high_cnt <= high_cnt + 1'b1;
            end
            // to_armed makes the timeout fire once per silent interval even
            // though idle_cnt sits at its saturation value afterwards.
            if (rise || fall) begin
                idle_cnt <= '0;
                to_armed <= 1'b1;
            end else begin
                if (idle_cnt != CNT_SAT) idle_cnt <= idle_cnt + 1'b1;
                if (disarm)              to_armed <= 1'b0;
            end
        end
    end

    // Numerator rounds to nearest: (15H + P/2) / P. H <= P keeps it below 16P.
    logic [NW-1:0]     num;
    logic [DUTY_W-1:0] div_q;
    logic              div_start, div_done;

    assign num = NW'(high_cnt) * NW'(DUTY_SCALE) + NW'(per_cnt >> 1);

    pwm_duty_div #(.CNT_W(CNT_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .n     (num),
        .p     (per_cnt),
        .q     (div_q),
        .done  (div_done)
    );

    // FSM
    pwm_cap_state_t    state, state_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic              valid_nxt;

    assign tmo = to_armed && (idle_cnt == CNT_SAT) && !(rise || fall);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            duty       <= duty_nxt;
            duty_valid <= valid_nxt;
        end
    end

    // Timeout is ignored in DIVIDE; to_armed stays set so it is taken on
    // the first cycle back in MEASURE.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        valid_nxt = 1'b0;
        div_start = 1'b0;
        disarm    = 1'b0;
        case (state)
            IDLE: begin
                if (tmo) begin
                    duty_nxt  = s ? DUTY_W'(DUTY_MAX) : '0;
                    valid_nxt = 1'b1;
                    disarm    = 1'b1;
                end else if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    div_start = 1'b1;
                    state_nxt = DIVIDE;
                end else if (tmo) begin
                    duty_nxt  = s ? DUTY_W'(DUTY_MAX) : '0;
                    valid_nxt = 1'b1;
                    disarm    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    duty_nxt  = div_q;
                    valid_nxt = 1'b1;
                    state_nxt = MEASURE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign active = (state != IDLE);

endmodule
